// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_PERF_W = 32;
    localparam int unsigned MD_CYCLES_DEFAULT = 4;

    localparam logic [FWD_W-1:0] FWD_RD  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdState_t;

    // Operand forwarding select; the younger Memory-stage result wins over Writeback.
    function automatic logic [FWD_W-1:0] fwdSelect(
        input logic             regWriteM,
        input logic [REG_W-1:0] rdM,
        input logic             regWriteW,
        input logic [REG_W-1:0] rdW,
        input logic [REG_W-1:0] rs
    );
        if (regWriteM && (rdM == rs) && (rdM != '0)) begin
            return FWD_MEM;
        end
        if (regWriteW && (rdW == rs) && (rdW != '0)) begin
            return FWD_WB;
        end
        return FWD_RD;
    endfunction

endpackage

// File: rtl/hazard_unit_md_sequencer.sv
// Mul/div sequencer: holds the pipeline for MD_CYCLES cycles and emits start/done pulses.
import hazard_pkg::*;

module md_sequencer #(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MulDivE,
    output logic mdStall,
    output logic MDStartE,
    output logic MDDoneE
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);
    // The IDLE cycle that accepts the op is the first stall cycle, so BUSY lasts one fewer.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdState_t         state;
    mdState_t         stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Accept is gated by rst_n so a held MulDivE cannot stall the pipe during reset.
    always_comb begin
        stateNext = state;
        countNext = count;
        mdStall   = 1'b0;
        MDStartE  = 1'b0;
        MDDoneE   = 1'b0;
        case (state)
            IDLE: begin
                if (MulDivE && rst_n) begin
                    stateNext = BUSY;
                    countNext = CNT_LOAD;
                    mdStall   = 1'b1;
                    MDStartE  = 1'b1;
                end
            end
            BUSY: begin
                mdStall = 1'b1;
                if (count <= CNT_ONE) begin
                    stateNext = DONE;
                    countNext = '0;
                end else begin
                    countNext = count - CNT_ONE;
                end
            end
            DONE: begin
                MDDoneE   = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and mul/div stall.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
import hazard_pkg::*;

module hazard_unit #(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        MulDivE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        MDStartE,
    output logic        MDDoneE,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    logic lwStall;
    logic mdStall;

    assign ForwardAE = fwdSelect(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
    assign ForwardBE = fwdSelect(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

    assign lwStall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    md_sequencer #(
        .MD_CYCLES(MD_CYCLES)
    ) u_mdSeq (
        .clk     (clk),
        .rst_n   (rst_n),
        .MulDivE (MulDivE),
        .mdStall (mdStall),
        .MDStartE(MDStartE),
        .MDDoneE (MDDoneE)
    );

    // A mul/div in flight freezes F/D/E and bubbles M; branch and load-use wait behind it.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (mdStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF = lwStall;
            StallD = lwStall;
            FlushD = PCSrcE;
            FlushE = lwStall || PCSrcE;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_PERF_W-1:0] stallCnt;
    logic [CNT_PERF_W-1:0] flushCnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (StallF && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_PERF_W'(1);
            end
            if (FlushE && (flushCnt != '1)) begin
                flushCnt <= flushCnt + CNT_PERF_W'(1);
            end
        end
    end

    assign StallCount = stallCnt;
    assign FlushCount = flushCnt;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with MD_CYCLES=4.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MDStartE, MDDoneE;
    logic [31:0] StallCount, FlushCount;
    logic [7:0]  ctl;

    int passCnt = 0;
    int totalCnt = 0;

    hazard_unit #(.MD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MDStartE(MDStartE), .MDDoneE(MDDoneE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MDStartE, MDDoneE}
    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MDStartE, MDDoneE};

    task automatic drive_quiet();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MulDivE = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_quiet();
        MulDivE = 1'b1;
        #2;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        totalCnt++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0)
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", StallCount, FlushCount);
        else passCnt++;
        MulDivE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL reset_release_ctl got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
    endtask

    task automatic test_forward();
        @(negedge clk);
        RdM = 5'd3; RdW = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        totalCnt++;
        if (ForwardAE !== 2'b10) $display("FAIL fwd_a_mem got=%b exp=10", ForwardAE);
        else passCnt++;
        totalCnt++;
        if (ForwardBE !== 2'b10) $display("FAIL fwd_b_mem got=%b exp=10", ForwardBE);
        else passCnt++;
        RegWriteM = 1'b0;
        #1;
        totalCnt++;
        if (ForwardAE !== 2'b01) $display("FAIL fwd_a_wb got=%b exp=01", ForwardAE);
        else passCnt++;
        totalCnt++;
        if (ForwardBE !== 2'b01) $display("FAIL fwd_b_wb got=%b exp=01", ForwardBE);
        else passCnt++;
        Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        #1;
        totalCnt++;
        if (ForwardAE !== 2'b00) $display("FAIL fwd_a_x0 got=%b exp=00", ForwardAE);
        else passCnt++;
        RdM = 5'd7; Rs2E = 5'd7; RdW = 5'd9; Rs1E = 5'd9; RegWriteW = 1'b1;
        #1;
        totalCnt++;
        if (ForwardAE !== 2'b01 || ForwardBE !== 2'b10)
            $display("FAIL fwd_split got=%b/%b exp=01/10", ForwardAE, ForwardBE);
        else passCnt++;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL fwd_no_ctl got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        drive_quiet();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ResultSrcE0 = 1'b1; RdE = 5'd5; Rs2D = 5'd5; Rs1D = 5'd1;
        #1;
        totalCnt++;
        if (ctl !== 8'b1100_1000) $display("FAIL lw_rs2 got=%b exp=%b", ctl, 8'b1100_1000);
        else passCnt++;
        RdE = 5'd0; Rs2D = 5'd0;
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL lw_x0 got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        RdE = 5'd9; Rs1D = 5'd9;
        #1;
        totalCnt++;
        if (ctl !== 8'b1100_1000) $display("FAIL lw_rs1 got=%b exp=%b", ctl, 8'b1100_1000);
        else passCnt++;
        ResultSrcE0 = 1'b0;
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL lw_not_load got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        drive_quiet();
    endtask

    task automatic test_branch();
        @(negedge clk);
        PCSrcE = 1'b1;
        #1;
        totalCnt++;
        if (ctl !== 8'b0001_1000) $display("FAIL branch got=%b exp=%b", ctl, 8'b0001_1000);
        else passCnt++;
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        #1;
        totalCnt++;
        if (ctl !== 8'b1101_1000) $display("FAIL branch_lw got=%b exp=%b", ctl, 8'b1101_1000);
        else passCnt++;
        drive_quiet();
    endtask

    task automatic test_muldiv();
        @(negedge clk);
        MulDivE = 1'b1; PCSrcE = 1'b1;
        #1;
        totalCnt++;
        if (ctl !== 8'b1110_0110) $display("FAIL md_c0 got=%b exp=%b", ctl, 8'b1110_0110);
        else passCnt++;
        PCSrcE = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ResultSrcE0 = 1'b1; RdE = 5'd5; Rs2D = 5'd5; PCSrcE = (c == 2);
            #1;
            totalCnt++;
            if (ctl !== 8'b1110_0100) $display("FAIL md_busy_c%0d got=%b exp=%b", c, ctl, 8'b1110_0100);
            else passCnt++;
        end
        @(negedge clk);
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0001) $display("FAIL md_done_c4 got=%b exp=%b", ctl, 8'b0000_0001);
        else passCnt++;
        @(negedge clk);
        MulDivE = 1'b0;
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL md_idle_c5 got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        drive_quiet();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        MulDivE = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            #1;
            totalCnt++;
            if (c == 0 || c == 5) begin
                if (ctl !== 8'b1110_0110) $display("FAIL b2b_start_c%0d got=%b exp=%b", c, ctl, 8'b1110_0110);
                else passCnt++;
            end else if (c == 4) begin
                if (ctl !== 8'b0000_0001) $display("FAIL b2b_done_c%0d got=%b exp=%b", c, ctl, 8'b0000_0001);
                else passCnt++;
            end else begin
                if (ctl !== 8'b1110_0100) $display("FAIL b2b_busy_c%0d got=%b exp=%b", c, ctl, 8'b1110_0100);
                else passCnt++;
            end
            @(negedge clk);
        end
        MulDivE = 1'b0;
        // Abort the restarted op so the next scenario begins from IDLE.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_quiet();
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        MulDivE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        totalCnt++;
        if (ctl !== 8'b1110_0100) $display("FAIL mrst_busy got=%b exp=%b", ctl, 8'b1110_0100);
        else passCnt++;
        rst_n = 1'b0;
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL mrst_async got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        @(negedge clk);
        totalCnt++;
        if (ctl !== 8'b0000_0000) $display("FAIL mrst_held got=%b exp=%b", ctl, 8'b0);
        else passCnt++;
        MulDivE = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            totalCnt++;
            if (ctl !== 8'b0000_0000) $display("FAIL mrst_idle_c%0d got=%b exp=%b", c, ctl, 8'b0);
            else passCnt++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        MulDivE = 1'b1;
        #1;
        totalCnt++;
        if (ctl !== 8'b1110_0110) $display("FAIL post_rst_start got=%b exp=%b", ctl, 8'b1110_0110);
        else passCnt++;
        @(negedge clk);
        MulDivE = 1'b0;
        #1;
        totalCnt++;
        if (ctl !== 8'b1110_0100) $display("FAIL post_rst_busy got=%b exp=%b", ctl, 8'b1110_0100);
        else passCnt++;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        totalCnt++;
        if (ctl !== 8'b0000_0001) $display("FAIL post_rst_done got=%b exp=%b", ctl, 8'b0000_0001);
        else passCnt++;
        drive_quiet();
    endtask

    task automatic test_perf();
        logic [31:0] expStall;
        logic [31:0] expFlush;
`ifdef HAZARD_PERF_CNT_EN
        expStall = 32'd5;
        expFlush = 32'd1;
`else
        expStall = 32'd0;
        expFlush = 32'd0;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        drive_quiet();
        @(negedge clk);
        rst_n = 1'b1;
        MulDivE = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge clk);
        MulDivE = 1'b0;
        ResultSrcE0 = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
        @(negedge clk);
        drive_quiet();
        #1;
        totalCnt++;
        if (StallCount !== expStall) $display("FAIL perf_stall got=%0d exp=%0d", StallCount, expStall);
        else passCnt++;
        totalCnt++;
        if (FlushCount !== expFlush) $display("FAIL perf_flush got=%0d exp=%0d", FlushCount, expFlush);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_muldiv();
        test_back_to_back();
        test_mid_reset();
        test_perf();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be clocked on the rising edge of clk and cleared asynchronously when rst_n is low.
REQ-002 The block SHALL have one parameter: MD_CYCLES, default 4, the number of stall cycles for a multi-cycle (mul/div) op; legal range is 2..64.
REQ-003 The ports SHALL be, in this order:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
- RdM, RdW  in  5  destinations in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  writeback enables for M and W.
- ResultSrcE0  in  1  Execute instruction is a load.
- PCSrcE  in  1  branch/jump taken in Execute.
- MulDivE  in  1  Execute instruction is multi-cycle.
- ForwardAE, ForwardBE  out  2  operand mux selects.
- StallF, StallD, StallE  out  1  pipeline register hold.
- FlushD, FlushE, FlushM  out  1  bubble insertion.
- MDStartE, MDDoneE  out  1  mul/div unit handshake pulses.
- StallCount, FlushCount  out  32  performance counters.

Function
REQ-004 ForwardAE SHALL be combinational: 2'b10 if RegWriteM & RdM==Rs1E & RdM!=0; else 2'b01 if RegWriteW & RdW==Rs1E & RdW!=0; else 2'b00. ForwardBE SHALL follow the same rule using Rs2E. The M match SHALL take priority over the W match.
REQ-005 lwStall SHALL be ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-006 The mul/div sequencer SHALL have three states, IDLE, BUSY and DONE, with these transitions:
- IDLE -> BUSY on MulDivE.
- BUSY -> DONE after the programmed count.
- DONE -> IDLE unconditionally.
REQ-007 For a MulDivE first seen in IDLE at cycle 0:
- StallF, StallD and StallE SHALL be 1 for exactly cycles 0..MD_CYCLES-1.
- FlushM SHALL be 1 for the same cycles.
- The sequencer SHALL be in DONE at cycle MD_CYCLES, with all stalls 0.
REQ-008 MDStartE SHALL pulse for one cycle at cycle 0; the mul/div unit latches its operands on this pulse.
REQ-009 MDDoneE SHALL pulse for one cycle in DONE; the datapath selects the mul/div result on this pulse.
REQ-010 MulDivE SHALL be ignored while in BUSY or DONE, so the op that just completed is not restarted.
REQ-011 When no mul/div stall is active:
- StallF and StallD SHALL each be 1 if lwStall.
- FlushD SHALL be PCSrcE.
- FlushE SHALL be lwStall | PCSrcE.
- StallE and FlushM SHALL be 0.
REQ-012 While a mul/div stall is active, FlushD and FlushE SHALL be forced to 0 and lwStall SHALL be ignored; the mul/div stall dominates.
REQ-013 When PCSrcE and MulDivE are both 1 in IDLE, the sequencer SHALL start and the mul/div stall SHALL take precedence.
REQ-014 The internal down-counter SHALL be $clog2(MD_CYCLES+1) bits wide and SHALL never wrap.

Reset
REQ-015 On rst_n low, state SHALL become IDLE, the counter SHALL become 0, and all registered outputs and counters SHALL become 0 immediately.
REQ-016 A reset during BUSY SHALL abort the op: MDDoneE SHALL not pulse, and stalls SHALL drop asynchronously.
REQ-017 After rst_n deasserts, the first rising edge SHALL evaluate MulDivE normally.

Configuration
REQ-018 With HAZARD_PERF_CNT_EN defined:
- StallCount SHALL increment on every cycle in which StallF is 1.
- FlushCount SHALL increment on every cycle in which FlushE is 1.
- Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-019 Without HAZARD_PERF_CNT_EN, both counter ports SHALL remain present and SHALL be tied to 32'h0, with no counter flops.

Structure
REQ-020 Package hazard_pkg SHALL hold:
- the state enum (IDLE, BUSY, DONE);
- the forward-select constants FWD_RD=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10;
- the MD_CYCLES default.
REQ-021 The FSM and counter SHALL live in the sub-module md_sequencer. Its outputs SHALL be mdStall, MDStartE and MDDoneE. Forwarding, load-use and flush logic SHALL stay in the top level.

Verification
REQ-022 Forward priority: RdM=RdW=Rs1E=3, RegWriteM=RegWriteW=1 -> ForwardAE=2'b10. Then RegWriteM=0 -> ForwardAE=2'b01. Then Rs1E=0 with RdM=RdW=0 -> ForwardAE=2'b00.
REQ-023 Load-use: ResultSrcE0=1, RdE=5, Rs2D=5 -> StallF=StallD=FlushE=1 and StallE=0. With RdE=0 instead -> no stall.
REQ-024 Branch: PCSrcE=1 in IDLE with MulDivE=0 -> FlushD=FlushE=1 and StallF=0.
REQ-025 Mul/div with MD_CYCLES=4: MulDivE held high from cycle 0 -> MDStartE at cycle 0, StallE and FlushM for cycles 0..3, MDDoneE at cycle 4, and no restart at cycle 5 unless a new MulDivE arrives then.
REQ-026 Mid-op reset: rst_n low at cycle 2 of a mul/div -> all stalls 0 at once, no MDDoneE, and IDLE after release.
REQ-027 With HAZARD_PERF_CNT_EN: the REQ-025 sequence followed by one load-use event -> StallCount=5 and FlushCount=1.
